// File: rtl/cdb_arbiter16.sv
// Round-robin arbiter for the 16-source common data bus.
// Registered one-hot grant with a hold timeout and zero-bubble handover.
//
// state | meaning
// IDLE  | no owner; grant outputs zero, waiting for any request
// OWN   | grant_idx owns the bus; hcnt counts cycles held so far
module cdb_arbiter16 #(
  parameter int MAX_HOLD = 8,
  parameter int HCW      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic        timeout,
  output logic        any_req
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  state_t         state, state_n;
  logic [15:0]    grant_n;
  logic           valid_n;
  logic [3:0]     idx_n;
  logic           timeout_n;
  logic [3:0]     ptr, ptr_n;
  logic [HCW-1:0] hcnt, hcnt_n;
  logic [15:0]    others;
  logic [3:0]     idle_sel, hand_sel, next_ptr;

  // Lowest circular index >= p whose mask bit is set.
  function automatic logic [3:0] pick(input logic [15:0] mask, input logic [3:0] p);
    logic [3:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = p + 4'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign any_req  = |req;
  assign next_ptr = grant_idx + 4'd1;
  assign others   = req & ~(16'd1 << grant_idx);
  assign idle_sel = pick(req, ptr);
  assign hand_sel = pick(others, next_ptr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
      ptr         <= '0;
      hcnt        <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_valid <= valid_n;
      grant_idx   <= idx_n;
      timeout     <= timeout_n;
      ptr         <= ptr_n;
      hcnt        <= hcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    valid_n   = grant_valid;
    idx_n     = grant_idx;
    timeout_n = 1'b0;
    ptr_n     = ptr;
    hcnt_n    = hcnt;
    case (state)
      IDLE: begin
        grant_n = '0;
        valid_n = 1'b0;
        idx_n   = '0;
        hcnt_n  = '0;
        if (|req) begin
          grant_n = 16'd1 << idle_sel;
          valid_n = 1'b1;
          idx_n   = idle_sel;
          state_n = OWN;
        end
      end
      OWN: begin
        if (req[grant_idx] && (hcnt < HOLD_LAST)) begin
          hcnt_n = hcnt + HCW'(1);
        end else begin
          // Still requesting here means the hold limit forced the release.
          timeout_n = req[grant_idx];
          ptr_n     = next_ptr;
          hcnt_n    = '0;
          if (|others) begin
            grant_n = 16'd1 << hand_sel;
            valid_n = 1'b1;
            idx_n   = hand_sel;
          end else begin
            grant_n = '0;
            valid_n = 1'b0;
            idx_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
